seq_comparator: RTL and testbench

SEQ_COMPARATOR -- requirements
Module: seq_comparator

---
 rtl/seq_comparator_pkg.sv | 26 ++
 rtl/seq_comparator_digit_compare.sv | 50 +++++
 rtl/seq_comparator.sv | 136 +++++++++++++
 tb/tb_seq_comparator.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/seq_comparator_pkg.sv
// Shared definitions for the sequential comparator: FSM encoding and result-flag bundle.
package seq_comparator_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic gt;
      logic eq;
      logic lt;
   } flags_t;

   localparam flags_t FLAGS_NONE = '{gt: 1'b0, eq: 1'b0, lt: 1'b0};

   function automatic flags_t make_flags(input logic gt, input logic eq, input logic lt);
      flags_t f;
      f.gt = gt;
      f.eq = eq;
      f.lt = lt;
      return f;
   endfunction

endpackage

// File: rtl/seq_comparator_digit_compare.sv
// Gate-level magnitude compare of one DIGIT-wide slice; the MSB-first chain decides gt/lt.
module digit_compare
   import seq_comparator_pkg::*;
#(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   output logic             gt,
   output logic             eq,
   output logic             lt
);

   wire [DIGIT-1:0] w_na;
   wire [DIGIT-1:0] w_nb;
   wire [DIGIT-1:0] w_bit_gt;
   wire [DIGIT-1:0] w_bit_lt;
   wire [DIGIT-1:0] w_bit_eq;
   wire [DIGIT-1:0] w_take_gt;
   wire [DIGIT-1:0] w_take_lt;
   wire [DIGIT:0]   w_gt_acc;
   wire [DIGIT:0]   w_lt_acc;
   wire [DIGIT:0]   w_eq_acc;

   assign w_gt_acc[DIGIT] = 1'b0;
   assign w_lt_acc[DIGIT] = 1'b0;
   assign w_eq_acc[DIGIT] = 1'b1;

   // A lower bit only decides the result while every higher bit is still equal.
   genvar gi;
   generate
      for (gi = DIGIT - 1; gi >= 0; gi = gi - 1) begin : g_bit
         not  u_na     (w_na[gi], a[gi]);
         not  u_nb     (w_nb[gi], b[gi]);
         and  u_bgt    (w_bit_gt[gi], a[gi], w_nb[gi]);
         and  u_blt    (w_bit_lt[gi], w_na[gi], b[gi]);
         xnor u_beq    (w_bit_eq[gi], a[gi], b[gi]);
         and  u_tgt    (w_take_gt[gi], w_eq_acc[gi+1], w_bit_gt[gi]);
         and  u_tlt    (w_take_lt[gi], w_eq_acc[gi+1], w_bit_lt[gi]);
         or   u_gacc   (w_gt_acc[gi], w_gt_acc[gi+1], w_take_gt[gi]);
         or   u_lacc   (w_lt_acc[gi], w_lt_acc[gi+1], w_take_lt[gi]);
         and  u_eacc   (w_eq_acc[gi], w_eq_acc[gi+1], w_bit_eq[gi]);
      end
   endgenerate

   buf u_gt_out (gt, w_gt_acc[0]);
   buf u_lt_out (lt, w_lt_acc[0]);
   buf u_eq_out (eq, w_eq_acc[0]);

endmodule

// File: rtl/seq_comparator.sv
// Multi-cycle magnitude comparator: scans DIGIT bits per cycle from the MSB and stops
// at the first differing slice; signed mode uses the offset-binary trick at capture.
module seq_comparator
   import seq_comparator_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             signed_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             A_gt_B,
   output logic             A_eq_B,
   output logic             A_lt_B
);

   localparam int NSLICE = (DIGIT > 0) ? WIDTH / DIGIT : 1;
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NSLICE - 1);
   localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

   generate
      if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
         $error("seq_comparator: WIDTH must be a positive multiple of DIGIT");
      end
   endgenerate

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] w_a_next;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] w_b_next;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] w_idx_next;
   flags_t           r_flags;
   flags_t           w_flags_next;

   logic [DIGIT-1:0] w_slice_a;
   logic [DIGIT-1:0] w_slice_b;
   logic             w_dc_gt;
   logic             w_dc_eq;
   logic             w_dc_lt;

   // Operands are shifted left each SCAN cycle, so the active slice is always the top one.
   assign w_slice_a = r_a[WIDTH-1 -: DIGIT];
   assign w_slice_b = r_b[WIDTH-1 -: DIGIT];

   digit_compare #(
      .DIGIT (DIGIT)
   ) u_digit_compare (
      .a  (w_slice_a),
      .b  (w_slice_b),
      .gt (w_dc_gt),
      .eq (w_dc_eq),
      .lt (w_dc_lt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_idx   <= '0;
         r_flags <= FLAGS_NONE;
      end else begin
         r_state <= w_state_next;
         r_a     <= w_a_next;
         r_b     <= w_b_next;
         r_idx   <= w_idx_next;
         r_flags <= w_flags_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_a_next     = r_a;
      w_b_next     = r_b;
      w_idx_next   = r_idx;
      w_flags_next = r_flags;
      in_ready     = 1'b0;
      out_valid    = 1'b0;

      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               // Flipping both sign bits maps two's complement onto an unsigned order.
               w_a_next     = signed_mode ? (A ^ MSB_MASK) : A;
               w_b_next     = signed_mode ? (B ^ MSB_MASK) : B;
               w_idx_next   = IDX_TOP;
               w_flags_next = FLAGS_NONE;
               w_state_next = SCAN;
            end
         end

         SCAN: begin
            if (!w_dc_eq) begin
               w_flags_next = make_flags(w_dc_gt, 1'b0, w_dc_lt);
               w_state_next = DONE;
            end else if (r_idx == '0) begin
               w_flags_next = make_flags(1'b0, 1'b1, 1'b0);
               w_state_next = DONE;
            end else begin
               w_idx_next = r_idx - 1'b1;
               w_a_next   = r_a << DIGIT;
               w_b_next   = r_b << DIGIT;
            end
         end

         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_flags_next = FLAGS_NONE;
               w_state_next = IDLE;
            end
         end

         default: begin
            w_flags_next = FLAGS_NONE;
            w_state_next = IDLE;
         end
      endcase
   end

   assign A_gt_B = r_flags.gt;
   assign A_eq_B = r_flags.eq;
   assign A_lt_B = r_flags.lt;

endmodule

// File: tb/tb_seq_comparator.sv
// Bench for seq_comparator: a 16/4 instance with directed vectors and a 4/1 instance swept
// exhaustively, both checked every cycle against an arithmetic reference model.
module tb_seq_comparator;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic        iv16 = 1'b0, or16 = 1'b0, sm16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        ir16, ov16, gt16, eq16, lt16;

   logic        iv4 = 1'b0, or4 = 1'b0, sm4 = 1'b0;
   logic [3:0]  a4 = '0, b4 = '0;
   logic        ir4, ov4, gt4, eq4, lt4;

   seq_comparator #(.WIDTH(16), .DIGIT(4)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .A(a16), .B(b16),
      .signed_mode(sm16), .out_valid(ov16), .out_ready(or16),
      .A_gt_B(gt16), .A_eq_B(eq16), .A_lt_B(lt16));

   seq_comparator #(.WIDTH(4), .DIGIT(1)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .A(a4), .B(b4),
      .signed_mode(sm4), .out_valid(ov4), .out_ready(or4),
      .A_gt_B(gt4), .A_eq_B(eq4), .A_lt_B(lt4));

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Expected transaction in flight per instance; acc is the cycle count seen after the accept edge.
   bit       act16 = 1'b0, act4 = 1'b0;
   logic [2:0] ef16 = '0, ef4 = '0;
   int       el16 = 0, el4 = 0, ea16 = 0, ea4 = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, got, want);
      end
   endtask

   // Flags {gt,eq,lt} from integer comparison; latency from the first differing digit.
   function automatic void model(input int w, input int d, input logic [15:0] a,
                                 input logic [15:0] b, input logic sm,
                                 output logic [2:0] f, output int lat);
      int va, vb, sa, sb;
      va  = int'(a) & ((1 << w) - 1);
      vb  = int'(b) & ((1 << w) - 1);
      lat = w / d;
      for (int i = 0; i < w / d; i++) begin
         sa = (va >> (w - (i + 1) * d)) & ((1 << d) - 1);
         sb = (vb >> (w - (i + 1) * d)) & ((1 << d) - 1);
         if (sa != sb) begin
            lat = i + 1;
            break;
         end
      end
      if (sm) begin
         if (va >= (1 << (w - 1))) va = va - (1 << w);
         if (vb >= (1 << (w - 1))) vb = vb - (1 << w);
      end
      f = (va > vb) ? 3'b100 : ((va == vb) ? 3'b010 : 3'b001);
   endfunction

   always @(negedge clk) begin : cmp
      logic       ov_e;
      logic [2:0] f_e;
      ov_e = act16 && ((cyc - ea16) >= el16);
      f_e  = ov_e ? ef16 : 3'b000;
      chk("d16_in_ready", 32'(ir16), 32'(!act16));
      chk("d16_out_valid", 32'(ov16), 32'(ov_e));
      chk("d16_flags", 32'({gt16, eq16, lt16}), 32'(f_e));
      ov_e = act4 && ((cyc - ea4) >= el4);
      f_e  = ov_e ? ef4 : 3'b000;
      chk("d4_in_ready", 32'(ir4), 32'(!act4));
      chk("d4_out_valid", 32'(ov4), 32'(ov_e));
      chk("d4_flags", 32'({gt4, eq4, lt4}), 32'(f_e));
   end

   task automatic run(input bit w4, input logic [15:0] a, input logic [15:0] b,
                      input logic sm, input int hold, input bit rel);
      logic [2:0] f;
      int lat, n;
      model(w4 ? 4 : 16, w4 ? 1 : 4, a, b, sm, f, lat);
      @(negedge clk);
      if (rel) rst_n = 1'b1;
      if (w4) begin a4 = a[3:0]; b4 = b[3:0]; sm4 = sm; iv4 = 1'b1; or4 = (hold == 0); end
      else    begin a16 = a; b16 = b; sm16 = sm; iv16 = 1'b1; or16 = (hold == 0); end
      @(posedge clk);
      if (w4) begin ef4 = f; el4 = lat; ea4 = cyc + 1; act4 = 1'b1; end
      else    begin ef16 = f; el16 = lat; ea16 = cyc + 1; act16 = 1'b1; end
      #1;
      // Scrambled inputs while busy must not disturb the captured operands.
      if (w4) begin iv4 = 1'b0; a4 = ~a4; b4 = 4'($urandom); sm4 = ~sm; end
      else    begin iv16 = 1'b0; a16 = ~a16; b16 = 16'($urandom); sm16 = ~sm; end
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(w4 ? ov4 : ov16) && n < 40);
      if (n >= 40) begin
         total++;
         bad++;
         $display("FAIL timeout w4=%0d a=%0h b=%0h got=no_out_valid want=out_valid", w4, a, b);
      end
      if (hold > 0) begin
         if (w4) begin iv4 = 1'b1; a4 = ~a[3:0]; b4 = ~b[3:0]; end
         else    begin iv16 = 1'b1; a16 = ~a; b16 = ~b; end
         repeat (hold) @(negedge clk);
         if (w4) begin iv4 = 1'b0; or4 = 1'b1; end
         else    begin iv16 = 1'b0; or16 = 1'b1; end
      end
      @(posedge clk);
      if (w4) act4 = 1'b0;
      else    act16 = 1'b0;
      $display("txn w4=%0d sm=%0d a=%0h b=%0h exp_flags=%b exp_lat=%0d", w4, sm, a, b, f, lat);
   endtask

   task automatic pin(input bit w4, input logic [15:0] a, input logic [15:0] b, input logic sm,
                      input logic [2:0] f_l, input int lat_l);
      logic [2:0] f;
      int lat;
      model(w4 ? 4 : 16, w4 ? 1 : 4, a, b, sm, f, lat);
      chk("pin_flags", 32'(f), 32'(f_l));
      chk("pin_lat", 32'(lat), 32'(lat_l));
      run(w4, a, b, sm, 0, 1'b0);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1;
      chk("rst_in_ready16", 32'(ir16), 1);
      chk("rst_out_valid16", 32'(ov16), 0);
      chk("rst_flags16", 32'({gt16, eq16, lt16}), 0);
      chk("rst_in_ready4", 32'(ir4), 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      pin(1'b0, 16'h1234, 16'h1234, 1'b0, 3'b010, 4);
      pin(1'b0, 16'h9000, 16'h1FFF, 1'b0, 3'b100, 1);
      pin(1'b0, 16'h9000, 16'h1FFF, 1'b1, 3'b001, 1);
      pin(1'b0, 16'h00A0, 16'h00A1, 1'b0, 3'b001, 4);
      pin(1'b0, 16'hFFFF, 16'h0000, 1'b1, 3'b001, 1);
      pin(1'b0, 16'h7FFF, 16'h8000, 1'b1, 3'b100, 1);
      pin(1'b1, 16'h0008, 16'h0007, 1'b1, 3'b001, 1);
      pin(1'b1, 16'h0005, 16'h0004, 1'b0, 3'b100, 4);

      // Result held through backpressure while new operands are offered.
      run(1'b0, 16'h0050, 16'h0040, 1'b0, 3, 1'b0);

      // Reset in the second SCAN cycle aborts the transaction.
      @(negedge clk);
      a16 = 16'h1234; b16 = 16'h1234; sm16 = 1'b0; iv16 = 1'b1; or16 = 1'b1;
      @(posedge clk);
      ef16 = 3'b010; el16 = 4; ea16 = cyc + 1; act16 = 1'b1;
      #1 iv16 = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 act16 = 1'b0;
      chk("arst_in_ready", 32'(ir16), 1);
      chk("arst_out_valid", 32'(ov16), 0);
      chk("arst_flags", 32'({gt16, eq16, lt16}), 0);
      run(1'b0, 16'h8001, 16'h8002, 1'b1, 0, 1'b1);

      for (int i = 0; i < 12; i++)
         run(1'b0, 16'($urandom), 16'($urandom), 1'(i % 2), 0, 1'b0);

      for (int s = 0; s < 2; s++)
         for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
               run(1'b1, 16'(a), 16'(b), 1'(s), 0, 1'b0);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
